// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 neighbourhood generator with two line buffers and a registered window.
// Optional WIN_FRAME_DONE_EN macro adds a registered end-of-frame pulse output.
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic [7:0] in4,
  output logic [7:0] in5,
  output logic [7:0] in6,
  output logic [7:0] in7,
  output logic [7:0] in8,
  output logic [7:0] in9,
`ifdef WIN_FRAME_DONE_EN
  output logic       frame_done,
`endif
  output logic       window_valid
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic          wv_q, wv_d;
  logic          fd_q, fd_d;
  logic [7:0]    top, mid;

  // Line buffers are never reset; window_valid gating makes stale contents harmless.
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    wv_d  = 1'b0;
    fd_d  = 1'b0;
    top   = lb2[col_q];
    mid   = lb1[col_q];
    if (pixel_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;
      wv_d     = (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_HEIGHT - 1)) begin
          row_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      wv_q  <= 1'b0;
      fd_q  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      wv_q  <= wv_d;
      fd_q  <= fd_d;
      win_q <= win_d;
    end
  end

  // Read-before-write: top/mid above sample the old contents in the same cycle.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb2[col_q] <= mid;
      lb1[col_q] <= pixel_in;
    end
  end

  assign in1          = win_q[0];
  assign in2          = win_q[1];
  assign in3          = win_q[2];
  assign in4          = win_q[3];
  assign in5          = win_q[4];
  assign in6          = win_q[5];
  assign in7          = win_q[6];
  assign in8          = win_q[7];
  assign in9          = win_q[8];
  assign window_valid = wv_q;

`ifdef WIN_FRAME_DONE_EN
  assign frame_done = fd_q;
`else
  logic unused_fd;
  assign unused_fd = fd_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen at 8x6 with pixel = row*16+col.
module tb_window_3x3_gen;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic [7:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic       window_valid;
`ifdef WIN_FRAME_DONE_EN
  logic       frame_done;
`endif

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .in8(in8), .in9(in9),
`ifdef WIN_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .window_valid(window_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fd_chk(input bit exp);
`ifdef WIN_FRAME_DONE_EN
    chk("frame_done", {7'd0, frame_done}, {7'd0, exp});
`else
    if (exp) begin end
`endif
  endtask

  task automatic send(input bit v, input logic [7:0] px);
    pixel_in    = px;
    pixel_valid = v;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    if (window_valid === 1'b1) pulses++;
  endtask

  // Expected window after accepting pixel (r,c), straight from the raster definition.
  task automatic check_pixel(input int r, input int c);
    bit exp_v;
    exp_v = (r >= 2) && (c >= 2);
    chk($sformatf("valid(%0d,%0d)", r, c), {7'd0, window_valid}, {7'd0, exp_v});
    if (exp_v) begin
      chk("in1", in1, 8'((r - 2) * 16 + c - 2));
      chk("in3", in3, 8'((r - 2) * 16 + c));
      chk("in5", in5, 8'((r - 1) * 16 + c - 1));
      chk("in7", in7, 8'(r * 16 + c - 2));
      chk("in9", in9, 8'(r * 16 + c));
    end
    fd_chk((r == H - 1) && (c == W - 1));
  endtask

  task automatic run_frame(input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1'b1, 8'(r * 16 + c));
        check_pixel(r, c);
        if (gaps) begin
          send(1'b0, 8'hFF);
          chk("idle_valid", {7'd0, window_valid}, 8'd0);
          chk("idle_hold_in9", in9, 8'(r * 16 + c));
          fd_chk(1'b0);
        end
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {7'd0, window_valid}, 8'd0);
    chk("rst_in1", in1, 8'h00);
    chk("rst_in9", in9, 8'h00);
    fd_chk(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame
    pulses = 0;
    run_frame(1'b0);
    chk("f1_pulses", 8'(pulses), 8'd24);
    chk("f1_last_in1", in1, 8'h35);
    chk("f1_last_in9", in9, 8'h57);

    // Gapped frame, follows the previous frame directly
    pulses = 0;
    run_frame(1'b1);
    chk("gap_pulses", 8'(pulses), 8'd24);

    // Two frames back to back
    pulses = 0;
    run_frame(1'b0);
    run_frame(1'b0);
    chk("b2b_pulses", 8'(pulses), 8'd48);

    // Mid-frame asynchronous reset at pixel (3,4)
    for (int k = 0; k < 3 * W + 4; k++) begin
      send(1'b1, 8'((k / W) * 16 + (k % W)));
      check_pixel(k / W, k % W);
    end
    chk("pre_rst_valid", {7'd0, window_valid}, 8'd1);
    pixel_in    = 8'h34;
    pixel_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, window_valid}, 8'd0);
    chk("mid_rst_in1", in1, 8'h00);
    chk("mid_rst_in5", in5, 8'h00);
    chk("mid_rst_in9", in9, 8'h00);
    fd_chk(1'b0);
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 19; k++) begin
      send(1'b1, 8'((k / W) * 16 + (k % W)));
      chk($sformatf("post_rst_valid%0d", k), {7'd0, window_valid}, {7'd0, (k == 18)});
      check_pixel(k / W, k % W);
    end
    chk("post_rst_pulses", 8'(pulses), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
